// File: rtl/ring_hop_buffer.sv
//============================================================================
// Module   : ring_hop_buffer
// Brief    : Elastic bidirectional FIFO stage for one hop of the remote-data
//            ring. Optional perf counters are enabled by RING_HOP_PERF_EN.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module ring_hop_fifo #(
    parameter int DataWidth = 64,
    parameter int Depth     = 2,
    parameter int CntWidth  = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [DataWidth-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [CntWidth-1:0]  usage_o
`ifdef RING_HOP_PERF_EN
    ,
    output logic [31:0]          flits_o,
    output logic [31:0]          stall_o
`endif
);

    localparam int                   PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrWidth-1:0]  LastPtr  = PtrWidth'(Depth - 1);
    localparam logic [CntWidth-1:0]  FullCnt  = CntWidth'(Depth);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic                 w_push, w_pop;

    // Handshake signals depend only on the count register, so no input
    // combinationally reaches ready_o or valid_o.
    assign ready_o = (cnt_q != FullCnt);
    assign valid_o = (cnt_q != '0);
    assign w_push  = valid_i & ready_o;
    assign w_pop   = valid_o & ready_i;
    assign usage_o = cnt_q;
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrWidth'(1);
            end
            if (w_pop) begin
                rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrWidth'(1);
            end
            case ({w_push, w_pop})
                2'b10:   cnt_d = cnt_q + CntWidth'(1);
                2'b01:   cnt_d = cnt_q - CntWidth'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset; data_o is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

`ifdef RING_HOP_PERF_EN
    logic [31:0] flits_q, stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flits_q <= '0;
            stall_q <= '0;
        end else if (flush_i) begin
            flits_q <= '0;
            stall_q <= '0;
        end else begin
            if (w_pop && (flits_q != '1)) begin
                flits_q <= flits_q + 32'd1;
            end
            if (valid_o && !ready_i && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign flits_o = flits_q;
    assign stall_o = stall_q;
`endif

endmodule

module ring_hop_buffer #(
    parameter int DataWidth = 64,
    parameter int Depth     = 2,
    parameter int CntWidth  = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic [DataWidth-1:0] lr_data_i,
    input  logic                 lr_valid_i,
    output logic                 lr_ready_o,
    output logic [DataWidth-1:0] lr_data_o,
    output logic                 lr_valid_o,
    input  logic                 lr_ready_i,
    input  logic [DataWidth-1:0] rl_data_i,
    input  logic                 rl_valid_i,
    output logic                 rl_ready_o,
    output logic [DataWidth-1:0] rl_data_o,
    output logic                 rl_valid_o,
    input  logic                 rl_ready_i,
    output logic [CntWidth-1:0]  lr_usage_o,
    output logic [CntWidth-1:0]  rl_usage_o
`ifdef RING_HOP_PERF_EN
    ,
    output logic [31:0]          lr_flits_o,
    output logic [31:0]          rl_flits_o,
    output logic [31:0]          lr_stall_o,
    output logic [31:0]          rl_stall_o
`endif
);

    ring_hop_fifo #(
        .DataWidth (DataWidth),
        .Depth     (Depth),
        .CntWidth  (CntWidth)
    ) u_lr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .data_i  (lr_data_i),
        .valid_i (lr_valid_i),
        .ready_o (lr_ready_o),
        .data_o  (lr_data_o),
        .valid_o (lr_valid_o),
        .ready_i (lr_ready_i),
        .usage_o (lr_usage_o)
`ifdef RING_HOP_PERF_EN
        ,
        .flits_o (lr_flits_o),
        .stall_o (lr_stall_o)
`endif
    );

    ring_hop_fifo #(
        .DataWidth (DataWidth),
        .Depth     (Depth),
        .CntWidth  (CntWidth)
    ) u_rl (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .data_i  (rl_data_i),
        .valid_i (rl_valid_i),
        .ready_o (rl_ready_o),
        .data_o  (rl_data_o),
        .valid_o (rl_valid_o),
        .ready_i (rl_ready_i),
        .usage_o (rl_usage_o)
`ifdef RING_HOP_PERF_EN
        ,
        .flits_o (rl_flits_o),
        .stall_o (rl_stall_o)
`endif
    );

endmodule

`default_nettype wire

// File: tb/tb_ring_hop_buffer.sv
//============================================================================
// Module   : tb_ring_hop_buffer
// Brief    : Directed bench for ring_hop_buffer; instance k has Depth k+1.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_ring_hop_buffer;

    localparam int DW = 16;
    localparam logic [DW-1:0] RL_XOR = 16'h8000;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          flush = 1'b0;
    logic [DW-1:0] lr_di = '0, rl_di = '0;
    logic          lr_vi = 1'b0, rl_vi = 1'b0, lr_ri = 1'b0, rl_ri = 1'b0;
    logic [DW-1:0] lr_do [4];
    logic [DW-1:0] rl_do [4];
    logic [3:0]    lr_vo, lr_ro, rl_vo, rl_ro;
    logic [2:0]    lr_uo [4];
    logic [2:0]    rl_uo [4];
`ifdef RING_HOP_PERF_EN
    logic [31:0]   lr_fl [4];
    logic [31:0]   rl_fl [4];
    logic [31:0]   lr_st [4];
    logic [31:0]   rl_st [4];
`endif
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        localparam int CW = $clog2(k + 2);
        logic [CW-1:0] lu, ru;
        ring_hop_buffer #(.DataWidth(DW), .Depth(k + 1)) u_dut (
            .clk_i      (clk),
            .rst_ni     (rst_n),
            .flush_i    (flush),
            .lr_data_i  (lr_di),
            .lr_valid_i (lr_vi),
            .lr_ready_o (lr_ro[k]),
            .lr_data_o  (lr_do[k]),
            .lr_valid_o (lr_vo[k]),
            .lr_ready_i (lr_ri),
            .rl_data_i  (rl_di),
            .rl_valid_i (rl_vi),
            .rl_ready_o (rl_ro[k]),
            .rl_data_o  (rl_do[k]),
            .rl_valid_o (rl_vo[k]),
            .rl_ready_i (rl_ri),
            .lr_usage_o (lu),
            .rl_usage_o (ru)
`ifdef RING_HOP_PERF_EN
            ,
            .lr_flits_o (lr_fl[k]),
            .rl_flits_o (rl_fl[k]),
            .lr_stall_o (lr_st[k]),
            .rl_stall_o (rl_st[k])
`endif
        );
        assign lr_uo[k] = 3'(lu);
        assign rl_uo[k] = 3'(ru);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Same stimulus on both directions; the right-to-left payload is tagged.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
        lr_vi = v;
        rl_vi = v;
        lr_di = d;
        rl_di = d ^ RL_XOR;
        lr_ri = r;
        rl_ri = r;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0);
        flush = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        drive(1'b0, '0, 1'b0);
        rst_n = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({lr_vo[k], lr_ro[k], lr_uo[k], lr_do[k]} !== {1'b0, 1'b1, 3'd0, 16'h0}) begin
                n_err++;
                $display("FAIL reset_lr[%0d]: got v=%b r=%b u=%0d d=%h, want v=0 r=1 u=0 d=0000",
                         k, lr_vo[k], lr_ro[k], lr_uo[k], lr_do[k]);
            end
            n_cmp++;
            if ({rl_vo[k], rl_ro[k], rl_uo[k], rl_do[k]} !== {1'b0, 1'b1, 3'd0, 16'h0}) begin
                n_err++;
                $display("FAIL reset_rl[%0d]: got v=%b r=%b u=%0d d=%h, want v=0 r=1 u=0 d=0000",
                         k, rl_vo[k], rl_ro[k], rl_uo[k], rl_do[k]);
            end
        end
        rst_n = 1'b1;
        tick();
    endtask

    // Depth=2 with ready_i=1: one flit per cycle, occupancy stays at 1.
    task automatic test_stream();
        do_reset();
        for (int i = 1; i <= 100; i++) begin
            drive(1'b1, DW'(i), 1'b1);
            tick();
            n_cmp++;
            if ({lr_vo[1], lr_ro[1], lr_uo[1], lr_do[1]} !== {1'b1, 1'b1, 3'd1, DW'(i)}) begin
                n_err++;
                $display("FAIL stream_lr flit %0d: got v=%b r=%b u=%0d d=%h, want v=1 r=1 u=1 d=%h",
                         i, lr_vo[1], lr_ro[1], lr_uo[1], lr_do[1], DW'(i));
            end
            n_cmp++;
            if ({rl_vo[1], rl_ro[1], rl_uo[1], rl_do[1]} !== {1'b1, 1'b1, 3'd1, DW'(i) ^ RL_XOR}) begin
                n_err++;
                $display("FAIL stream_rl flit %0d: got v=%b r=%b u=%0d d=%h, want v=1 r=1 u=1 d=%h",
                         i, rl_vo[1], rl_ro[1], rl_uo[1], rl_do[1], DW'(i) ^ RL_XOR);
            end
        end
        drive(1'b0, '0, 1'b1);
        tick();
        n_cmp++;
        if ({lr_vo[1], lr_uo[1], rl_vo[1], rl_uo[1]} !== {1'b0, 3'd0, 1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL stream_drain: got lr v=%b u=%0d rl v=%b u=%0d, want all 0",
                     lr_vo[1], lr_uo[1], rl_vo[1], rl_uo[1]);
        end
    endtask

    // Depth=4 backpressure; producer holds an unaccepted flit.
    task automatic test_backpressure();
        int di_t [11] = '{1, 2, 3, 4, 5, 5, 5, 6, 0, 0, 0};
        int vi_t [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        int ri_t [11] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
        int u_t  [11] = '{1, 2, 3, 4, 4, 3, 3, 3, 2, 1, 0};
        int d_t  [11] = '{1, 1, 1, 1, 1, 2, 3, 4, 5, 6, 0};
        int r_t  [11] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
        logic ev;
        do_reset();
        for (int s = 0; s < 11; s++) begin
            drive(1'(vi_t[s]), DW'(di_t[s]), 1'(ri_t[s]));
            tick();
            ev = (u_t[s] != 0);
            n_cmp++;
            if (lr_uo[3] !== 3'(u_t[s]) || lr_vo[3] !== ev || lr_ro[3] !== 1'(r_t[s]) ||
                (ev && lr_do[3] !== DW'(d_t[s]))) begin
                n_err++;
                $display("FAIL bp_lr step %0d: got u=%0d v=%b r=%b d=%h, want u=%0d v=%b r=%0d d=%h",
                         s, lr_uo[3], lr_vo[3], lr_ro[3], lr_do[3], u_t[s], ev, r_t[s], DW'(d_t[s]));
            end
            n_cmp++;
            if (rl_uo[3] !== 3'(u_t[s]) || rl_vo[3] !== ev || rl_ro[3] !== 1'(r_t[s]) ||
                (ev && rl_do[3] !== (DW'(d_t[s]) ^ RL_XOR))) begin
                n_err++;
                $display("FAIL bp_rl step %0d: got u=%0d v=%b r=%b d=%h, want u=%0d v=%b r=%0d d=%h",
                         s, rl_uo[3], rl_vo[3], rl_ro[3], rl_do[3], u_t[s], ev, r_t[s],
                         DW'(d_t[s]) ^ RL_XOR);
            end
        end
    endtask

    // Depth=3, random valid/ready, scoreboard of 1000 flits.
    task automatic test_wrap();
        int q[$];
        int seq = 1;
        int got = 0;
        int cyc = 0;
        int exp_v;
        do_reset();
        rl_vi = 1'b0;
        while (got < 1000 && cyc < 20000) begin
            lr_vi = ($urandom_range(0, 1) == 1);
            lr_ri = ($urandom_range(0, 1) == 1);
            lr_di = DW'(seq);
            n_cmp++;
            if ({lr_ro[2], lr_vo[2], lr_uo[2]} !== {q.size() != 3, q.size() != 0, 3'(q.size())}) begin
                n_err++;
                $display("FAIL wrap_state cyc %0d: got r=%b v=%b u=%0d, want occupancy %0d",
                         cyc, lr_ro[2], lr_vo[2], lr_uo[2], q.size());
            end
            if (lr_vo[2] && lr_ri) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL wrap_spurious cyc %0d: got valid with d=%h, want empty", cyc, lr_do[2]);
                end else begin
                    exp_v = q.pop_front();
                    if (lr_do[2] !== DW'(exp_v)) begin
                        n_err++;
                        $display("FAIL wrap_data flit %0d: got %h, want %h", got, lr_do[2], DW'(exp_v));
                    end
                end
                got++;
            end
            if (lr_vi && lr_ro[2]) begin
                q.push_back(seq);
                seq++;
            end
            tick();
            cyc++;
        end
        lr_vi = 1'b0;
        n_cmp++;
        if (got != 1000) begin
            n_err++;
            $display("FAIL wrap_count: got %0d flits, want 1000", got);
        end
    endtask

    // Depth=1 sustains one flit every two cycles.
    task automatic test_depth1();
        int pops = 0;
        logic er, ev;
        do_reset();
        for (int n = 1; n <= 20; n++) begin
            drive(1'b1, DW'((n + 1) / 2), 1'b1);
            if (lr_vo[0] && lr_ri) pops++;
            tick();
            er = (n % 2 == 0);
            ev = (n % 2 == 1);
            n_cmp++;
            if (lr_ro[0] !== er || lr_vo[0] !== ev || (ev && lr_do[0] !== DW'((n + 1) / 2))) begin
                n_err++;
                $display("FAIL depth1 cyc %0d: got r=%b v=%b d=%h, want r=%b v=%b d=%h",
                         n, lr_ro[0], lr_vo[0], lr_do[0], er, ev, DW'((n + 1) / 2));
            end
        end
        drive(1'b0, '0, 1'b1);
        n_cmp++;
        if (pops != 10) begin
            n_err++;
            $display("FAIL depth1_rate: got %0d pops in 20 cycles, want 10", pops);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, DW'(i * 'h11), 1'b0);
            tick();
        end
        n_cmp++;
        if (lr_uo[3] !== 3'd3 || rl_uo[3] !== 3'd3) begin
            n_err++;
            $display("FAIL flush_fill: got lr u=%0d rl u=%0d, want 3", lr_uo[3], rl_uo[3]);
        end
        drive(1'b1, 16'h0055, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, '0, 1'b0);
        n_cmp++;
        if ({lr_uo[3], lr_vo[3], lr_ro[3], rl_uo[3], rl_vo[3], rl_ro[3]} !==
            {3'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL flush_clear: got lr u=%0d v=%b r=%b rl u=%0d v=%b r=%b, want u=0 v=0 r=1",
                     lr_uo[3], lr_vo[3], lr_ro[3], rl_uo[3], rl_vo[3], rl_ro[3]);
        end
        drive(1'b1, 16'h0077, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0);
        n_cmp++;
        if ({lr_uo[3], lr_vo[3], lr_do[3], rl_do[3]} !== {3'd1, 1'b1, 16'h0077, 16'h8077}) begin
            n_err++;
            $display("FAIL flush_refill: got u=%0d v=%b lr d=%h rl d=%h, want u=1 v=1 d=0077/8077",
                     lr_uo[3], lr_vo[3], lr_do[3], rl_do[3]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 16'h00a1, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({lr_vo[3], lr_ro[3], lr_uo[3], rl_vo[3], rl_ro[3], rl_uo[3]} !==
            {1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 3'd0}) begin
            n_err++;
            $display("FAIL async_reset: got lr v=%b r=%b u=%0d rl v=%b r=%b u=%0d, want v=0 r=1 u=0",
                     lr_vo[3], lr_ro[3], lr_uo[3], rl_vo[3], rl_ro[3], rl_uo[3]);
        end
        drive(1'b0, '0, 1'b0);
        #2;
        rst_n = 1'b1;
        tick();
    endtask

`ifdef RING_HOP_PERF_EN
    task automatic test_perf();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, DW'(i), 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0);
        tick();
        tick();
        drive(1'b0, '0, 1'b1);
        repeat (4) tick();
        for (int i = 5; i <= 10; i++) begin
            drive(1'b1, DW'(i), 1'b1);
            tick();
        end
        drive(1'b0, '0, 1'b1);
        tick();
        tick();
        n_cmp++;
        if (lr_fl[3] !== 32'd10 || lr_st[3] !== 32'd5) begin
            n_err++;
            $display("FAIL perf_lr: got flits=%0d stall=%0d, want 10/5", lr_fl[3], lr_st[3]);
        end
        n_cmp++;
        if (rl_fl[3] !== 32'd10 || rl_st[3] !== 32'd5) begin
            n_err++;
            $display("FAIL perf_rl: got flits=%0d stall=%0d, want 10/5", rl_fl[3], rl_st[3]);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++;
        if ({lr_fl[3], lr_st[3], rl_fl[3], rl_st[3]} !== 128'd0) begin
            n_err++;
            $display("FAIL perf_flush: got lr %0d/%0d rl %0d/%0d, want all 0",
                     lr_fl[3], lr_st[3], rl_fl[3], rl_st[3]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_wrap();
        test_depth1();
        test_flush();
        test_async_reset();
`ifdef RING_HOP_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
